// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the shot clock timer.
// to_bcd2 is only referenced when SHOT_CLOCK_BCD_EN is defined.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        StStopped = 2'd0,
        StRun     = 2'd1,
        StBuzz    = 2'd2,
        StExpired = 2'd3
    } state_e;

    localparam int unsigned DEF_FULL  = 24;
    localparam int unsigned DEF_SHORT = 14;

    // Binary (0..99) to packed two-digit BCD: {tens, units}.
    function automatic logic [7:0] to_bcd2(input logic [7:0] bin);
        logic [7:0] tens;
        logic [7:0] units;
        tens  = bin / 8'd10;
        units = bin % 8'd10;
        return (tens << 4) | units;
    endfunction

endpackage

// File: rtl/buzzer_pulse.sv
// Buzzer pulse generator: a loadable down-counter advanced by tick_en.
// start_i loads the duration and raises the buzzer; clear_i (a reload) wins over start_i.
module buzzer_pulse #(
    parameter int unsigned BuzzTicks = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_en_i,
    input  logic start_i,
    input  logic clear_i,
    output logic buzzer_o,
    output logic last_tick_o
);

    localparam int unsigned CntW = $clog2(BuzzTicks + 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(BuzzTicks);
    localparam logic [CntW-1:0] OneVal  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            buzz_q, buzz_d;

    // Next-state: clear beats start beats tick countdown.
    always_comb begin
        cnt_d  = cnt_q;
        buzz_d = buzz_q;
        if (clear_i) begin
            cnt_d  = '0;
            buzz_d = 1'b0;
        end else if (start_i) begin
            cnt_d  = LoadVal;
            buzz_d = 1'b1;
        end else if (tick_en_i && (cnt_q != '0)) begin
            cnt_d  = cnt_q - OneVal;
            buzz_d = (cnt_q != OneVal);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buzz_q <= buzz_d;
        end
    end

    assign buzzer_o    = buzz_q;
    // Tick that ends the pulse; the parent uses it to leave its buzz state.
    assign last_tick_o = tick_en_i && (cnt_q == OneVal) && !clear_i;

endmodule

// File: rtl/shot_clock_timer.sv
// Shot clock countdown with pause/resume, full/short reload, expiry flag and buzzer pulse.
// Optional macro SHOT_CLOCK_BCD_EN adds registered BCD outputs bcd_tens/bcd_units.
module shot_clock_timer
    import shot_clock_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned FULL_VALUE  = DEF_FULL,
    parameter int unsigned SHORT_VALUE = DEF_SHORT,
    parameter int unsigned BUZZ_TICKS  = 3
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tick_en,
    input  logic             run,
    input  logic             reload_full,
    input  logic             reload_short,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             buzzer
`ifdef SHOT_CLOCK_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units
`endif
);

    localparam logic [WIDTH-1:0] FullVal  = WIDTH'(FULL_VALUE);
    localparam logic [WIDTH-1:0] ShortVal = WIDTH'(SHORT_VALUE);
    localparam logic [WIDTH-1:0] OneVal   = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             reload;
    logic             buzz_start;
    logic             buzz_last;

    assign reload = reload_full | reload_short;

    // Next-state: reload overrides everything except reset; ticks act only in RUN/BUZZ.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        expired_d  = expired_q;
        buzz_start = 1'b0;
        if (reload) begin
            count_d   = reload_full ? FullVal : ShortVal;
            expired_d = 1'b0;
            state_d   = run ? StRun : StStopped;
        end else begin
            unique case (state_q)
                StStopped: begin
                    if (run) state_d = StRun;
                end
                StRun: begin
                    if (!run) begin
                        state_d = StStopped;
                    end else if (tick_en) begin
                        // count <= 1 also covers a degenerate zero load
                        if (count_q > OneVal) begin
                            count_d = count_q - OneVal;
                        end else begin
                            count_d    = '0;
                            expired_d  = 1'b1;
                            buzz_start = 1'b1;
                            state_d    = StBuzz;
                        end
                    end
                end
                StBuzz: begin
                    count_d = '0;
                    if (buzz_last) state_d = StExpired;
                end
                StExpired: begin
                    count_d   = '0;
                    expired_d = 1'b1;
                end
            endcase
        end
    end

    // Main state registers with synchronous active-low reset.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q   <= StStopped;
            count_q   <= FullVal;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    buzzer_pulse #(
        .BuzzTicks (BUZZ_TICKS)
    ) u_buzzer_pulse (
        .clk_i       (clock_in),
        .rst_ni      (reset_n),
        .tick_en_i   (tick_en),
        .start_i     (buzz_start),
        .clear_i     (reload),
        .buzzer_o    (buzzer),
        .last_tick_o (buzz_last)
    );

    assign count   = count_q;
    assign running = (state_q == StRun);
    assign expired = expired_q;

`ifdef SHOT_CLOCK_BCD_EN
    logic [7:0] bcd_q, bcd_d;

    assign bcd_d = to_bcd2(8'(count_d));

    // BCD register tracks count_d so both update in the same cycle.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            bcd_q <= to_bcd2(8'(FullVal));
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_tens  = bcd_q[7:4];
    assign bcd_units = bcd_q[3:0];
`endif

endmodule

// File: doc/shot_clock_timer.md
Name: shot_clock_timer

Overview:
Parametrised successor to the fixed 24-s countdown used on the basketball scoreboard. Counts down from a full value (24) or a short value (14) on each external 1 Hz tick while running, and supports pause/resume. On expiry it latches an expired flag and drives a buzzer pulse of configurable length. Sits between the scoreboard control FSM (run and reload commands) and the display and buzzer drivers.

Parameters:
WIDTH, 5, count register width in bits; must hold FULL_VALUE.
FULL_VALUE, 24, value loaded by reload_full and at reset.
SHORT_VALUE, 14, value loaded by reload_short; must be <= FULL_VALUE.
BUZZ_TICKS, 3, buzzer duration in tick_en pulses; must be >= 1.

Ports:
clock_in  input  1  single system clock; all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
tick_en  input  1  one-cycle 1 Hz enable pulse from the prescaler.
run  input  1  level: 1 = count, 0 = paused.
reload_full  input  1  one-cycle pulse: load FULL_VALUE.
reload_short  input  1  one-cycle pulse: load SHORT_VALUE.
count  output  WIDTH  current remaining seconds, binary.
running  output  1  1 while in RUN state.
expired  output  1  1 from the cycle count reaches 0 until the next reload or reset.
buzzer  output  1  buzzer drive.

Behaviour:
- Reset (reset_n=0 at posedge): count=FULL_VALUE, state=STOPPED, running=0, expired=0, buzzer=0, buzz counter=0.
- States: STOPPED, RUN, BUZZ, EXPIRED.
- STOPPED: count holds. If run=1, go to RUN on the next cycle.
- RUN: if run=0, go to STOPPED. Otherwise, on tick_en with count>1, decrement count. On tick_en with count==1, set count=0, expired=1, buzzer=1, buzz counter=BUZZ_TICKS, and go to BUZZ.
- BUZZ: count=0. Each tick_en decrements the buzz counter; when it reaches 0, buzzer=0 and the state goes to EXPIRED. The run input is ignored.
- EXPIRED: count=0, expired=1, buzzer=0. Only a reload leaves this state.
- Reload priority, per cycle: reset > reload_full > reload_short > tick decrement.
- Reload in any state:
  - count loads the selected value the next cycle.
  - expired=0, buzzer=0, buzz counter=0.
  - Next state is RUN if run=1, else STOPPED.
- Reload and tick_en in the same cycle: the reload wins and no decrement happens in that cycle.
- Reload of SHORT_VALUE while count < SHORT_VALUE raises count (legal).
- Registered outputs; latency 1 cycle from any input event to the outputs.
- count never wraps below 0. A tick while count==0 has no effect on count.
- Degenerate value: if the loaded value is 0 and run=1, the first tick_en enters BUZZ directly (expired=1, buzzer=1).
- running = (state==RUN).

Optional Feature:
Macro SHOT_CLOCK_BCD_EN.
- Defined: adds outputs bcd_tens[3:0] and bcd_units[3:0], the registered BCD form of count, updated in the same cycle as count (valid for count <= 99).
- Not defined: the ports and conversion logic are absent; count is binary only.

Decomposition:
- Package shot_clock_pkg holds:
  - state typedef (STOPPED, RUN, BUZZ, EXPIRED);
  - default constants DEF_FULL=24 and DEF_SHORT=14;
  - function to_bcd2 (binary to two BCD digits), used under SHOT_CLOCK_BCD_EN.
- One natural sub-module: buzzer_pulse. It is a loadable down-counter clocked by tick_en that outputs buzzer; it is started by the expiry event and cleared by a reload.

Test Plan:
1. Reset then run=1 → count stays 24 until the first tick; after 24 ticks count=0, expired=1, buzzer=1 for 3 ticks, then buzzer=0 with expired still 1.
2. Run for 5 ticks (count=19), run=0, apply 3 ticks → count stays 19, running=0; run=1 plus 1 tick → count=18.
3. At count=9, pulse reload_short → count=14 the next cycle; at count=20, pulse reload_short → count=14.
4. During BUZZ (buzzer=1), pulse reload_full with run=1 → buzzer=0 and expired=0 the next cycle, count=24, running=1.
5. reload_full and reload_short and tick_en all asserted in one cycle at count=10 → count=24, no decrement.
6. reset_n=0 mid-run at count=7 → all outputs return to reset values the next cycle. With SHOT_CLOCK_BCD_EN at count=14 → bcd_tens=1, bcd_units=4.
